ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 190 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Optional transfer watchdog is built only when PS2_TX_TIMEOUT_EN is defined.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int RTS_CYCLES     = 25,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic       clk_25MHz,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    // state     | meaning
    // IDLE      | lines released, waiting for tx_start
    // INHIBIT   | clock held low
    // RTS       | clock and data held low (start bit)
    // SEND      | device clocks out data, parity, stop
    // ACK       | sample device ACK on falling edge 11
    // WAIT_IDLE | wait for both lines high, then done
    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE} state_t;

    localparam int MAX_CYC = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    state_t            state, state_next;
    logic [1:0]        clk_sync, data_sync;
    logic [1:0]        clk_run, data_run;
    logic              clk_filt, data_filt, clk_filt_d;
    logic              fall;
    logic [CNT_W-1:0]  cnt;
    logic [7:0]        data_q;
    logic              parity_q;
    logic [3:0]        bit_idx;
    logic              data_lo;
    logic [9:0]        frame;
    logic              wd_hit;
    logic              in_xfer;

    assign frame   = {1'b1, parity_q, data_q};
    assign fall    = clk_filt_d & ~clk_filt;
    assign in_xfer = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);

    // Filtered line only follows after four consecutive disagreeing synchronised samples.
    always_ff @(posedge clk_25MHz or negedge reset) begin
        if (!reset) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            clk_run    <= 2'd0;
            data_run   <= 2'd0;
            clk_filt   <= 1'b1;
            data_filt  <= 1'b1;
            clk_filt_d <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk_in};
            data_sync  <= {data_sync[0], ps2_data_in};
            clk_filt_d <= clk_filt;
            if (clk_sync[1] == clk_filt) begin
                clk_run <= 2'd0;
            end else if (clk_run == 2'd3) begin
                clk_filt <= clk_sync[1];
                clk_run  <= 2'd0;
            end else begin
                clk_run <= clk_run + 2'd1;
            end
            if (data_sync[1] == data_filt) begin
                data_run <= 2'd0;
            end else if (data_run == 2'd3) begin
                data_filt <= data_sync[1];
                data_run  <= 2'd0;
            end else begin
                data_run <= data_run + 2'd1;
            end
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd;

    always_ff @(posedge clk_25MHz or negedge reset) begin
        if (!reset) begin
            wd <= '0;
        end else if (state == RTS && cnt == '0) begin
            wd <= WD_W'(TIMEOUT_CYCLES);
        end else if (in_xfer && wd != '0) begin
            wd <= wd - 1'b1;
        end
    end

    assign wd_hit = in_xfer && (wd == '0);
`else
    assign wd_hit = 1'b0;
`endif

    assign timeout     = wd_hit;
    assign busy        = (state != IDLE);
    assign ps2_data_oe = (state == RTS) || ((state == SEND) && data_lo);

    always_ff @(posedge clk_25MHz or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ps2_clk_oe = 1'b0;
        done       = 1'b0;
        ack_err    = 1'b0;
        case (state)
            IDLE:      if (tx_start) state_next = INHIBIT;
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (cnt == '0) state_next = RTS;
            end
            RTS: begin
                ps2_clk_oe = 1'b1;
                if (cnt == '0) state_next = SEND;
            end
            SEND:      if (fall && bit_idx == 4'd9) state_next = ACK;
            ACK: begin
                if (fall) begin
                    ack_err    = data_filt;
                    state_next = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_filt && data_filt) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default:   state_next = IDLE;
        endcase
        // Watchdog abort wins over any completion in the same cycle.
        if (wd_hit) begin
            state_next = IDLE;
            done       = 1'b0;
            ack_err    = 1'b0;
        end
    end

    always_ff @(posedge clk_25MHz or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            data_q   <= 8'h00;
            parity_q <= 1'b0;
            bit_idx  <= 4'd0;
            data_lo  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        data_q   <= tx_data;
                        parity_q <= ~^tx_data;
                        cnt      <= CNT_W'(INHIBIT_CYCLES - 1);
                        data_lo  <= 1'b1;
                    end
                end
                INHIBIT: begin
                    if (cnt == '0) cnt <= CNT_W'(RTS_CYCLES - 1);
                    else           cnt <= cnt - 1'b1;
                end
                RTS: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else           bit_idx <= 4'd0;
                end
                SEND: begin
                    if (fall) begin
                        data_lo <= ~frame[bit_idx];
                        bit_idx <= bit_idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomised scoreboard bench for ps2_host_tx with a behavioural PS/2 device model.
// Exercises the watchdog only when PS2_TX_TIMEOUT_EN is defined.
module tb_ps2_host_tx;
    localparam int INH = 2500;
    localparam int RTS = 25;
    localparam int TO  = 30000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       busy, done, ack_err, timeout;
    logic       dev_clk_lo = 1'b0, dev_data_lo = 1'b0;

    always #20 clk = ~clk;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_lo);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_lo);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TO)) dut (
        .clk_25MHz(clk), .reset(rst_n), .tx_data(tx_data), .tx_start(tx_start),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .busy(busy), .done(done), .ack_err(ack_err), .timeout(timeout));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    typedef struct { logic [7:0] data; bit ack; bit tmo; } exp_t;
    exp_t exp_q[$];

    // Device model: answers a request-to-send with 11 clock pulses, samples on rising edges.
    int         half = 40;
    bit         ack_en = 1'b1, mute = 1'b0, abort = 1'b0, dev_active = 1'b0;
    int         dev_edges = 0;
    logic [9:0] dev_frame = '0;
    logic       dev_start = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            if (!mute && !abort && rst_n && !ps2_clk_oe && ps2_data_oe) begin
                dev_active = 1'b1;
                dev_start  = ps2_data_in;
                dev_edges  = 0;
                for (int i = 1; i <= 11; i++) begin
                    repeat (half) @(negedge clk);
                    if (abort) break;
                    dev_clk_lo = 1'b1;
                    dev_edges  = i;
                    repeat (half) @(negedge clk);
                    dev_clk_lo = 1'b0;
                    if (abort) break;
                    if (i <= 10) dev_frame[i-1] = ps2_data_in;
                    if (i == 10 && ack_en) dev_data_lo = 1'b1;
                    if (i == 11) dev_data_lo = 1'b0;
                end
                dev_clk_lo  = 1'b0;
                dev_data_lo = 1'b0;
                dev_active  = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT reports completion or watchdog expiry.
    bit   ack_err_seen = 1'b0;
    bit   busy_fall_chk = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            ack_err_seen  = 1'b0;
            busy_fall_chk = 1'b0;
        end else begin
            if (busy_fall_chk) begin
                check("busy_after_done", busy, 0);
                busy_fall_chk = 1'b0;
            end
            if (ack_err) ack_err_seen = 1'b1;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", done, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_not_timeout_case", mon_e.tmo, 0);
                    check("frame_start_bit", dev_start, 0);
                    check("frame_bits", dev_frame,
                          {1'b1, ($countones(mon_e.data) % 2 == 0) ? 1'b1 : 1'b0, mon_e.data});
                    check("ack_err_seen", ack_err_seen, mon_e.ack ? 0 : 1);
                end
                ack_err_seen  = 1'b0;
                busy_fall_chk = 1'b1;
            end
            if (timeout) begin
                if (exp_q.size() == 0) begin
                    check("timeout_unexpected", timeout, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("timeout_case", mon_e.tmo, 1);
                end
            end
        end
    end

    task automatic start(input logic [7:0] d, input bit ack, input bit tmo);
        exp_t e;
        e.data = d; e.ack = ack; e.tmo = tmo;
        ack_en = ack;
        exp_q.push_back(e);
        @(posedge clk); #1;
        check("busy_before_start", busy, 0);
        tx_data  = d;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || dev_active || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("transfer_within_budget", (busy || dev_active) ? 1 : 0, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL global_time_limit actual=expired required=finished");
        $fatal(1);
    end

    initial begin
        int n, m;
        logic [7:0] d;
        bit a;

        repeat (5) @(negedge clk);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {done, ack_err, timeout}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Slow 12.5 kHz device: inhibit/RTS timing, ignored second start mid-SEND.
        half = 1000;
        start(8'hF4, 1'b1, 1'b0);
        n = 0;
        @(negedge clk);
        while (ps2_clk_oe && !ps2_data_oe && n < 5000) begin n++; @(negedge clk); end
        check("inhibit_cycles", n, INH);
        m = 0;
        while (ps2_clk_oe && ps2_data_oe && m < 200) begin m++; @(negedge clk); end
        check("rts_cycles", m, RTS);
        n = 0;
        while (dev_edges < 3 && n < 10000) begin n++; @(negedge clk); end
        check("reached_send", busy, 1);
        #5 tx_data = 8'h55; tx_start = 1'b1;
        @(posedge clk); #1 tx_start = 1'b0;
        wait_idle(40000);

        half = 40;
        start(8'hFF, 1'b1, 1'b0);
        wait_idle(6000);
        start(8'h00, 1'b1, 1'b0);
        wait_idle(6000);
        start(8'($urandom), 1'b0, 1'b0);
        wait_idle(6000);
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            a = ($urandom_range(0, 3) != 0);
            start(d, a, 1'b0);
            wait_idle(6000);
        end

        // Reset near falling edge 5 must release both lines at once and yield no done.
        start(8'hF4, 1'b1, 1'b0);
        n = 0;
        while (dev_edges < 5 && n < 10000) begin n++; @(negedge clk); end
        repeat (8) @(negedge clk);
        check("mid_send_busy", busy, 1);
        abort = 1'b1;
        exp_q.delete();
        #5 rst_n = 1'b0;
        #1;
        check("rst_mid_clk_oe", ps2_clk_oe, 0);
        check("rst_mid_data_oe", ps2_data_oe, 0);
        check("rst_mid_busy", busy, 0);
        n = 0;
        while (dev_active && n < 500) begin n++; @(negedge clk); end
        abort = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (300) @(negedge clk);
        start(8'hF4, 1'b1, 1'b0);
        wait_idle(6000);

`ifdef PS2_TX_TIMEOUT_EN
        mute = 1'b1;
        start(8'($urandom), 1'b1, 1'b1);
        n = 0;
        while (!(!ps2_clk_oe && ps2_data_oe) && n < 5000) begin n++; @(negedge clk); end
        m = 0;
        while (!timeout && m < TO + 10) begin @(negedge clk); m++; end
        check("timeout_latency", m, TO);
        @(negedge clk);
        check("tmo_clk_oe", ps2_clk_oe, 0);
        check("tmo_data_oe", ps2_data_oe, 0);
        check("tmo_busy", busy, 0);
        mute = 1'b0;
        repeat (100) @(negedge clk);
        check("tmo_scoreboard_drained", exp_q.size(), 0);
`endif

        repeat (50) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
